// File: rtl/da_pkg.sv
// Shared types and elaboration helpers for the DA FIR engine.
// Holds the FSM encoding, width derivation and parameter checks.
package da_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Output width: LUT word grown by the sample width.
   function automatic int calc_yw(input int lw, input int xw);
      return lw + xw;
   endfunction

   // Ceiling log2, never below 1 so counters keep at least one bit.
   function automatic int clog2(input int v);
      int n;
      n = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) n = i + 1;
      return (n < 1) ? 1 : n;
   endfunction

   // Legal parameter set for the engine.
   function automatic bit params_ok(input int taps, input int xw,
                                    input int bpc);
      return (taps >= 2) && (taps <= 6) && (bpc >= 1) &&
             (bpc <= xw) && ((xw % bpc) == 0);
   endfunction

endpackage

// File: rtl/da_fir_engine_if.sv
// Start/done evaluation handshake plus LUT programming bus.
// master drives requests, slave is the engine.
interface da_fir_engine_if
   import da_pkg::*;
#(
   parameter int TAPS = 4,
   parameter int XW   = 8,
   parameter int LW   = 10
);
   localparam int YW = calc_yw(LW, XW);

   logic [XW-1:0]   x_new;
   logic            start;
   logic            ready;
   logic            done;
   logic [YW-1:0]   y;
   logic            flush;
   logic            lut_we;
   logic [TAPS-1:0] lut_addr;
   logic [LW-1:0]   lut_data;
   logic            lut_rej;

   modport master (
      output x_new, start, flush, lut_we, lut_addr, lut_data,
      input  ready, done, y, lut_rej
   );

   modport slave (
      input  x_new, start, flush, lut_we, lut_addr, lut_data,
      output ready, done, y, lut_rej
   );

endinterface

// File: rtl/da_lut.sv
// Partial-sum LUT: one synchronous write port, BPC async reads.
// Writes arriving while the engine is busy are refused.
module da_lut
   import da_pkg::*;
#(
   parameter int TAPS = 4,
   parameter int LW   = 10,
   parameter int BPC  = 2
)(
   input  logic                       clk,
   input  logic                       r,
   input  logic                       busy,
   input  logic                       we,
   input  logic [TAPS-1:0]            waddr,
   input  logic [LW-1:0]              wdata,
   input  logic [BPC-1:0][TAPS-1:0]   raddr,
   output logic [BPC-1:0][LW-1:0]     rdata,
   output logic                       rej
);
   localparam int DEPTH = 1 << TAPS;

   logic [LW-1:0] mem [DEPTH];

   // Commit writes only while idle; contents survive reset.
   always_ff @(posedge clk) begin
      if (!r && we && !busy)
         mem[waddr] <= wdata;
   end

   // One-cycle reject pulse for a write attempted mid-evaluation.
   always_ff @(posedge clk) begin
      if (r) rej <= 1'b0;
      else   rej <= we && busy;
   end

   // Parallel slice lookups, one per bit handled this cycle.
   always_comb begin
      rdata = '0;
      for (int b = 0; b < BPC; b++)
         rdata[b] = mem[raddr[b]];
   end

endmodule

// File: rtl/da_fir_engine.sv
// Distributed-arithmetic FIR: delay line, MSB-first slice sequencer,
// loadable partial-sum LUT and a resolved two's-complement result.
module da_fir_engine
   import da_pkg::*;
#(
   parameter int TAPS = 4,
   parameter int XW   = 8,
   parameter int LW   = 10,
   parameter int BPC  = 2
)(
   input logic             clk,
   input logic             r,
   da_fir_engine_if.slave  bus
);
   localparam int YW  = calc_yw(LW, XW);
   localparam int NG  = XW / BPC;
   localparam int CW  = clog2(NG);
   localparam int XIW = clog2(XW);

   if (!params_ok(TAPS, XW, BPC)) begin : g_bad_params
      $error("da_fir_engine: illegal TAPS/XW/BPC combination");
   end

   state_t                     state;
   state_t                     state_nx;
   logic                       ready;
   logic                       busy;
   logic                       accept;
   logic                       do_flush;
   logic                       last;
   logic [CW-1:0]              cnt;
   logic [XW-1:0]              xd [TAPS];
   logic signed [YW-1:0]       acc;
   logic signed [YW-1:0]       acc_nx;
   logic signed [YW-1:0]       grp_sum;
   logic signed [YW-1:0]       term;
   logic signed [YW-1:0]       y_q;
   logic                       done_q;
   logic [XIW-1:0]             bit_j;
   logic [BPC-1:0][TAPS-1:0]   raddr;
   logic [BPC-1:0][LW-1:0]     rdata;

   assign do_flush = bus.flush && ready;
   assign accept   = bus.start && ready && !bus.flush;
   assign last     = (state == RUN) && (cnt == CW'(NG - 1));

   da_lut #(
      .TAPS (TAPS),
      .LW   (LW),
      .BPC  (BPC)
   ) u_lut (
      .clk   (clk),
      .r     (r),
      .busy  (busy),
      .we    (bus.lut_we),
      .waddr (bus.lut_addr),
      .wdata (bus.lut_data),
      .raddr (raddr),
      .rdata (rdata),
      .rej   (bus.lut_rej)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (r) state <= IDLE;
      else   state <= state_nx;
   end

   // Next state: accepted start enters RUN, last group returns to IDLE.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (last)   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      ready = (state == IDLE);
      busy  = (state == RUN);
   end

   // Slice addresses for the bits of the current group, MSB first.
   always_comb begin
      raddr = '0;
      bit_j = '0;
      for (int b = 0; b < BPC; b++) begin
         bit_j = XIW'(XW - 1 - BPC * int'(cnt) - b);
         for (int t = 0; t < TAPS; t++)
            raddr[b][t] = xd[t][bit_j];
      end
   end

   // Weighted group sum; the sample sign bit enters negated.
   always_comb begin
      grp_sum = '0;
      term    = '0;
      for (int b = 0; b < BPC; b++) begin
         term = YW'($signed(rdata[b])) <<< (BPC - 1 - b);
         if (cnt == '0 && b == 0) grp_sum = grp_sum - term;
         else                     grp_sum = grp_sum + term;
      end
      acc_nx = (acc <<< BPC) + grp_sum;
   end

   // Delay line, accumulator, counter and result register.
   always_ff @(posedge clk) begin
      if (r) begin
         for (int t = 0; t < TAPS; t++) xd[t] <= '0;
         cnt    <= '0;
         acc    <= '0;
         y_q    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (do_flush) begin
            for (int t = 0; t < TAPS; t++) xd[t] <= '0;
         end else if (accept) begin
            xd[0] <= bus.x_new;
            for (int t = 1; t < TAPS; t++) xd[t] <= xd[t-1];
         end
         if (accept) begin
            cnt <= '0;
            acc <= '0;
         end else if (state == RUN) begin
            acc <= acc_nx;
            cnt <= cnt + CW'(1);
            if (last) begin
               y_q    <= acc_nx;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign bus.ready = ready;
   assign bus.done  = done_q;
   assign bus.y     = y_q;

endmodule

// File: tb/tb_da_fir_engine.sv
// Directed-vector bench for da_fir_engine (BPC=2 and BPC=1 builds).
// Expected results are queued at start; a monitor checks each done.
module tb_da_fir_engine;

   typedef struct {
      longint y;
      longint c0;
   } sb_t;

   logic   clk = 1'b0;
   logic   r   = 1'b1;
   longint cyc = 0;
   int     n_vec = 0;
   int     n_err = 0;
   sb_t    q0[$];
   sb_t    q1[$];

   da_fir_engine_if #(.TAPS(4), .XW(8), .LW(10)) bus0 ();
   da_fir_engine_if #(.TAPS(4), .XW(8), .LW(10)) bus1 ();

   da_fir_engine #(.TAPS(4), .XW(8), .LW(10), .BPC(2)) dut0 (
      .clk (clk),
      .r   (r),
      .bus (bus0.slave)
   );

   da_fir_engine #(.TAPS(4), .XW(8), .LW(10), .BPC(1)) dut1 (
      .clk (clk),
      .r   (r),
      .bus (bus1.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 0) ? bus0.ready : bus1.ready;
   endfunction

   task automatic mon(input int sel, input logic [17:0] yv);
      sb_t e;
      if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_done dut%0d: got y=%0d expected no done",
                  sel, longint'($signed(yv)));
      end else begin
         e = (sel == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("y dut%0d", sel), longint'($signed(yv)), e.y);
         chk($sformatf("latency dut%0d", sel), cyc - e.c0,
             (sel == 0) ? 4 : 8);
      end
   endtask

   always @(negedge clk) begin
      if (bus0.done) mon(0, bus0.y);
      if (bus1.done) mon(1, bus1.y);
   end

   task automatic lut_wr(input int sel, input int a, input int d);
      if (sel == 0) begin
         bus0.lut_we = 1'b1; bus0.lut_addr = 4'(a); bus0.lut_data = 10'(d);
      end else begin
         bus1.lut_we = 1'b1; bus1.lut_addr = 4'(a); bus1.lut_data = 10'(d);
      end
      @(negedge clk);
      bus0.lut_we = 1'b0;
      bus1.lut_we = 1'b0;
      chk("lut_rej_idle", (sel == 0) ? bus0.lut_rej : bus1.lut_rej, 0);
   endtask

   task automatic prog(input int sel, input int w0, input int w1,
                       input int w2, input int w3);
      int w[4];
      w = '{w0, w1, w2, w3};
      for (int k = 0; k < 16; k++) begin
         int s;
         s = 0;
         for (int i = 0; i < 4; i++) if (k[i]) s += w[i];
         lut_wr(sel, k, s);
      end
   endtask

   task automatic wait_idle(input int sel);
      int i;
      i = 0;
      while (rdy(sel) !== 1'b1 && i < 40) begin
         @(negedge clk);
         i++;
      end
      if (i >= 40) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout dut%0d: ready=0 after 40 cycles, need 1",
                  sel);
      end
   endtask

   task automatic start_eval(input int sel, input int x, input longint e);
      sb_t s;
      chk($sformatf("ready_at_start dut%0d", sel), rdy(sel), 1);
      s.y  = e;
      s.c0 = cyc + 1;
      if (sel == 0) begin
         bus0.x_new = 8'(x); bus0.start = 1'b1; q0.push_back(s);
      end else begin
         bus1.x_new = 8'(x); bus1.start = 1'b1; q1.push_back(s);
      end
      @(negedge clk);
      bus0.start = 1'b0;
      bus1.start = 1'b0;
   endtask

   task automatic flush0();
      bus0.flush = 1'b1;
      @(negedge clk);
      bus0.flush = 1'b0;
   endtask

   task automatic pulse_reset();
      r = 1'b1;
      @(negedge clk);
      r = 1'b0;
   endtask

   initial begin
      int b2b[3];
      int dr;
      bus0.x_new = '0; bus0.start = 1'b0; bus0.flush = 1'b0;
      bus0.lut_we = 1'b0; bus0.lut_addr = '0; bus0.lut_data = '0;
      bus1.x_new = '0; bus1.start = 1'b0; bus1.flush = 1'b0;
      bus1.lut_we = 1'b0; bus1.lut_addr = '0; bus1.lut_data = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", bus0.ready, 1);
      chk("rst_done", bus0.done, 0);
      chk("rst_y", bus0.y, 0);
      chk("rst_rej", bus0.lut_rej, 0);
      chk("rst_ready1", bus1.ready, 1);
      r = 1'b0;

      // w=(1,2,3,4), samples 1,2,4,8
      prog(0, 1, 2, 3, 4);
      wait_idle(0); start_eval(0, 1, 1);
      wait_idle(0); start_eval(0, 2, 4);
      wait_idle(0); start_eval(0, 4, 11);
      wait_idle(0); start_eval(0, 8, 26);
      wait_idle(0);

      // sign-bit term and full-range product
      pulse_reset();
      lut_wr(0, 1, 1);
      start_eval(0, -128, -128);
      wait_idle(0);
      lut_wr(0, 1, -512);
      flush0();
      start_eval(0, -128, 65536);
      wait_idle(0);

      // all taps at -128, LUT[15]=10
      prog(0, 1, 2, 3, 4);
      flush0();
      start_eval(0, -128, -128);
      wait_idle(0); start_eval(0, -128, -384);
      wait_idle(0); start_eval(0, -128, -768);
      wait_idle(0); start_eval(0, -128, -1280);
      wait_idle(0);

      // start during RUN is ignored
      start_eval(0, 5, -1147);
      bus0.start = 1'b1; bus0.x_new = 8'd7;
      chk("busy_ready_a", bus0.ready, 0);
      @(negedge clk);
      chk("busy_ready_b", bus0.ready, 0);
      @(negedge clk);
      bus0.start = 1'b0;
      wait_idle(0);

      // LUT write during RUN is refused
      start_eval(0, 0, -886);
      bus0.lut_we = 1'b1; bus0.lut_addr = 4'd8; bus0.lut_data = 10'd100;
      @(negedge clk);
      bus0.lut_we = 1'b0;
      chk("rej_pulse", bus0.lut_rej, 1);
      @(negedge clk);
      chk("rej_clear", bus0.lut_rej, 0);
      wait_idle(0); start_eval(0, 0, -497);
      wait_idle(0); start_eval(0, 0, 20);
      wait_idle(0);

      // reset two cycles into RUN abandons the evaluation
      bus0.x_new = 8'd3; bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      @(negedge clk);
      r = 1'b1;
      @(negedge clk);
      r = 1'b0;
      chk("midrst_ready", bus0.ready, 1);
      chk("midrst_y", bus0.y, 0);
      chk("midrst_done", bus0.done, 0);
      start_eval(0, 2, 2);
      wait_idle(0); start_eval(0, 1, 5);

      // back-to-back starts in the done cycle
      b2b = '{9, 14, 10};
      for (int i = 0; i < 3; i++) begin
         wait_idle(0);
         chk("b2b_in_done_cycle", bus0.done, 1);
         start_eval(0, 1, b2b[i]);
      end
      wait_idle(0);

      // flush and start together: flush wins
      bus0.flush = 1'b1; bus0.start = 1'b1; bus0.x_new = 8'd7;
      @(negedge clk);
      bus0.flush = 1'b0; bus0.start = 1'b0;
      chk("flush_start_ready", bus0.ready, 1);
      start_eval(0, 3, 3);
      wait_idle(0);

      // BPC=1 build, same filter
      prog(1, 1, 2, 3, 4);
      start_eval(1, -128, -128);
      wait_idle(1); start_eval(1, -128, -384);
      wait_idle(1); start_eval(1, -128, -768);
      wait_idle(1); start_eval(1, -128, -1280);

      dr = 0;
      while ((q0.size() + q1.size()) != 0 && dr < 60) begin
         @(negedge clk);
         dr++;
      end
      chk("pending_results", q0.size() + q1.size(), 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
